// File: rtl/fme_satd_acc_multi.sv
// Multi-candidate 4xN SATD accumulator: per-channel saturating sums over a programmable
// number of 4x4 beats, then a sequential argmin of sat(sum + MV-cost bias) across channels.
module fme_satd_acc_multi #(
    parameter int CH_NUM  = 8,
    parameter int SATD4_W = 13,
    parameter int ACC_W   = 17,
    parameter int CNT_W   = 5,
    parameter int IDX_W   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            blk_num_i,
    input  logic [CH_NUM*ACC_W-1:0]     bias_i,
    input  logic                        satd_valid_i,
    input  logic [CH_NUM*SATD4_W-1:0]   satd_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic [CNT_W-1:0]            beat_cnt_o,
    output logic [CH_NUM*ACC_W-1:0]     satd_o,
    output logic                        done_o,
    output logic [IDX_W-1:0]            best_idx_o,
    output logic [ACC_W-1:0]            best_cost_o
);

    typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q  [CH_NUM];
    logic [ACC_W-1:0]   bias_q [CH_NUM];
    logic [CNT_W-1:0]   blk_num_q, beat_cnt_q;
    logic [IDX_W-1:0]   cmp_idx_q, run_idx_q, best_idx_q;
    logic [ACC_W-1:0]   run_cost_q, best_cost_q;

    logic               start_ok, beat, last_beat, last_ch, better;
    logic [ACC_W-1:0]   cur_cost;

    // Sum at ACC_W+1 bits so the carry tells us when to clamp to all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign start_ok  = (state_q == IDLE) && start_i && (blk_num_i != '0);
    assign beat      = (state_q == ACC) && satd_valid_i && !abort_i;
    assign last_beat = beat && ((beat_cnt_q + CNT_W'(1)) == blk_num_q);
    assign last_ch   = (cmp_idx_q == IDX_W'(CH_NUM - 1));
    assign cur_cost  = sat_add(acc_q[cmp_idx_q], bias_q[cmp_idx_q]);
    assign better    = (cmp_idx_q == '0) || (cur_cost < run_cost_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = ACC;
            ACC:  if (abort_i) state_d = IDLE; else if (last_beat) state_d = CMP;
            CMP:  if (abort_i) state_d = IDLE; else if (last_ch) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    // The running best lives apart from best_* so an abort leaves the published result intact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < CH_NUM; k++) begin
                acc_q[k]  <= '0;
                bias_q[k] <= '0;
            end
            blk_num_q   <= '0;
            beat_cnt_q  <= '0;
            cmp_idx_q   <= '0;
            run_idx_q   <= '0;
            run_cost_q  <= '0;
            best_idx_q  <= '0;
            best_cost_q <= '0;
        end else begin
            if (start_ok) begin
                for (int k = 0; k < CH_NUM; k++) begin
                    acc_q[k]  <= '0;
                    bias_q[k] <= bias_i[k*ACC_W +: ACC_W];
                end
                blk_num_q  <= blk_num_i;
                beat_cnt_q <= '0;
                cmp_idx_q  <= '0;
            end
            if (beat) begin
                for (int k = 0; k < CH_NUM; k++)
                    acc_q[k] <= sat_add(acc_q[k], ACC_W'(satd_i[k*SATD4_W +: SATD4_W]));
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if ((state_q == CMP) && !abort_i) begin
                cmp_idx_q <= cmp_idx_q + IDX_W'(1);
                if (better) begin
                    run_idx_q  <= cmp_idx_q;
                    run_cost_q <= cur_cost;
                end
                if (last_ch) begin
                    best_idx_q  <= better ? cmp_idx_q : run_idx_q;
                    best_cost_q <= better ? cur_cost : run_cost_q;
                end
            end
        end
    end

    always_comb begin
        satd_o = '0;
        for (int k = 0; k < CH_NUM; k++)
            satd_o[k*ACC_W +: ACC_W] = acc_q[k];
    end

    assign beat_cnt_o  = beat_cnt_q;
    assign best_idx_o  = best_idx_q;
    assign best_cost_o = best_cost_q;

endmodule
